// File: rtl/xf100_exu_malu.sv
// xf100_exu_malu: multi-cycle RV32I ALU with an iterative shifter and a held valid/ready result register
module xf100_exu_malu #(
    parameter int XLEN = 32,
    parameter int RFIDX_W = 5,
    parameter int SHAMT_W = 5,
    parameter int SHIFT_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [10:0]        i_info,
    input  logic [XLEN-1:0]    i_rs1,
    input  logic [XLEN-1:0]    i_rs2,
    input  logic [XLEN-1:0]    i_imm,
    input  logic               i_rd_en,
    input  logic [RFIDX_W-1:0] i_rdidx,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               o_ready,
    output logic               o_wbck_en,
    output logic [XLEN-1:0]    o_wbck_data,
    output logic [RFIDX_W-1:0] o_wbck_rdidx,
    output logic               o_busy
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [SHAMT_W:0] STEP_MAX = (SHAMT_W+1)'(SHIFT_STEP);
    state_t state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d, data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0] kind_q, kind_d;
    logic rd_en_q, rd_en_d, valid_q, valid_d, wbck_en_q, wbck_en_d;
    logic [RFIDX_W-1:0] rdidx_q, rdidx_d, wbidx_q, wbidx_d;
    logic accept, is_shift, load_in, load_sh;
    logic [SHAMT_W-1:0] shamt, step, rem_nx;
    logic [XLEN-1:0] alu_res, sra_res, sh_res;
    logic [XLEN:0] slt_diff, sltu_diff;
    assign i_ready = (state_q == IDLE) && (!valid_q || o_ready) && !i_flush;
    assign accept = i_valid && i_ready;
    assign is_shift = i_info[2] | i_info[6] | i_info[7];
    assign shamt = i_rs2[SHAMT_W-1:0];
    assign load_in = accept && (!is_shift || shamt == '0);
    assign slt_diff = {i_rs1[XLEN-1], i_rs1} - {i_rs2[XLEN-1], i_rs2};
    assign sltu_diff = {1'b0, i_rs1} - {1'b0, i_rs2};
    assign alu_res = ({XLEN{i_info[0]}} & (i_rs1 + i_rs2))
                   | ({XLEN{i_info[1]}} & (i_rs1 - i_rs2))
                   | ({XLEN{i_info[3]}} & {{(XLEN-1){1'b0}}, slt_diff[XLEN]})
                   | ({XLEN{i_info[4]}} & {{(XLEN-1){1'b0}}, sltu_diff[XLEN]})
                   | ({XLEN{i_info[5]}} & (i_rs1 ^ i_rs2))
                   | ({XLEN{i_info[8]}} & (i_rs1 | i_rs2))
                   | ({XLEN{i_info[9]}} & (i_rs1 & i_rs2))
                   | ({XLEN{i_info[10]}} & i_imm);
    // kind: 0 SLL, 1 SRL, 2 SRA
    assign step = ({1'b0, rem_q} < STEP_MAX) ? rem_q : STEP_MAX[SHAMT_W-1:0];
    assign rem_nx = rem_q - step;
    assign sra_res = XLEN'($signed(acc_q) >>> step);
    assign sh_res = (kind_q == 2'd2) ? sra_res : (kind_q == 2'd1) ? (acc_q >> step) : (acc_q << step);
    assign load_sh = (state_q == SHIFT) && (rem_nx == '0);
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        rem_d = rem_q;
        kind_d = kind_q;
        rd_en_d = rd_en_q;
        rdidx_d = rdidx_q;
        valid_d = valid_q && !o_ready;
        wbck_en_d = wbck_en_q;
        data_d = data_q;
        wbidx_d = wbidx_q;
        if (load_in || load_sh) begin
            valid_d = 1'b1;
            wbck_en_d = load_in ? i_rd_en : rd_en_q;
            wbidx_d = load_in ? i_rdidx : rdidx_q;
            data_d = !load_in ? sh_res : is_shift ? i_rs1 : alu_res;
        end
        if (accept && is_shift && shamt != '0) begin
            state_d = SHIFT;
            acc_d = i_rs1;
            rem_d = shamt;
            kind_d = i_info[7] ? 2'd2 : i_info[6] ? 2'd1 : 2'd0;
            rd_en_d = i_rd_en;
            rdidx_d = i_rdidx;
        end
        if (state_q == SHIFT) begin
            acc_d = sh_res;
            rem_d = rem_nx;
            state_d = (rem_nx == '0) ? IDLE : SHIFT;
        end
        if (i_flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            rem_q <= '0;
            kind_q <= '0;
            rd_en_q <= 1'b0;
            rdidx_q <= '0;
            valid_q <= 1'b0;
            wbck_en_q <= 1'b0;
            data_q <= '0;
            wbidx_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            kind_q <= kind_d;
            rd_en_q <= rd_en_d;
            rdidx_q <= rdidx_d;
            valid_q <= valid_d;
            wbck_en_q <= wbck_en_d;
            data_q <= data_d;
            wbidx_q <= wbidx_d;
        end
    end
    assign o_valid = valid_q;
    assign o_wbck_en = wbck_en_q;
    assign o_wbck_data = data_q;
    assign o_wbck_rdidx = wbidx_q;
    assign o_busy = (state_q != IDLE) || valid_q;
endmodule

// File: tb/tb_xf100_exu_malu.sv
// tb_xf100_exu_malu: randomized scoreboard bench for the multi-cycle ALU against an arithmetic reference model
module tb_xf100_exu_malu;
    localparam int STEP = 4;
    localparam logic [10:0] ADD = 11'h001, SLL = 11'h004, SLT = 11'h008, SLTU = 11'h010, XOR = 11'h020;
    localparam logic [10:0] SRL = 11'h040, SRA = 11'h080, AND = 11'h200, LUI = 11'h400;
    logic clk = 0, rst = 1;
    logic i_valid = 0, i_ready, i_rd_en = 0, i_flush = 0, o_valid, o_ready = 1, o_wbck_en, o_busy;
    logic [10:0] i_info = 0;
    logic [31:0] i_rs1 = 0, i_rs2 = 0, i_imm = 0, o_wbck_data;
    logic [4:0] i_rdidx = 0, o_wbck_rdidx;
    typedef struct {
        logic [31:0] data;
        logic en;
        logic [4:0] idx;
        int lat;
        int acc;
    } exp_t;
    exp_t q[$];
    int cyc = 0, compared = 0, mismatched = 0;
    bit rand_ready = 0, fresh = 1, held = 0;
    logic [31:0] h_data;
    logic h_en;
    logic [4:0] h_idx;

    xf100_exu_malu #(.XLEN(32), .RFIDX_W(5), .SHAMT_W(5), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_info(i_info),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_rd_en(i_rd_en), .i_rdidx(i_rdidx),
        .i_flush(i_flush), .o_valid(o_valid), .o_ready(o_ready), .o_wbck_en(o_wbck_en),
        .o_wbck_data(o_wbck_data), .o_wbck_rdidx(o_wbck_rdidx), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] model(logic [10:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
        int sh = int'(b[4:0]);
        logic [31:0] r = 0;
        if (f[7]) return $signed(a) >>> sh;
        if (f[6]) return a >> sh;
        if (f[2]) return a << sh;
        if (f[0]) r |= a + b;
        if (f[1]) r |= a - b;
        if (f[3]) r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (f[4]) r |= (a < b) ? 32'd1 : 32'd0;
        if (f[5]) r |= a ^ b;
        if (f[8]) r |= a | b;
        if (f[9]) r |= a & b;
        if (f[10]) r |= imm;
        return r;
    endfunction

    function automatic int latency(logic [10:0] f, logic [31:0] b);
        int sh = int'(b[4:0]);
        return ((f[2] | f[6] | f[7]) && sh > 0) ? 1 + (sh + STEP - 1) / STEP : 1;
    endfunction

    task automatic issue(input logic [10:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic en, input logic [4:0] idx);
        bit ok = 0;
        int n_acc = 0;
        i_valid = 1; i_info = f; i_rs1 = a; i_rs2 = b; i_imm = imm; i_rd_en = en; i_rdidx = idx;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (i_ready) begin ok = 1; n_acc = cyc; end
        end
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout: i_ready stayed %0b, required 1", i_ready);
            i_valid = 0;
            return;
        end
        @(posedge clk);
        q.push_back('{model(f, a, b, imm), en, idx, latency(f, b), n_acc});
        #1 i_valid = 0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) o_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            fresh = 1; held = 0;
        end else if (o_valid) begin
            if (q.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL spurious_valid: o_valid=1 data=%0h with nothing expected", o_wbck_data);
            end else begin
                if (fresh) check("latency", cyc - q[0].acc, q[0].lat);
                if (held) begin
                    check("hold_data", o_wbck_data, h_data);
                    check("hold_en", o_wbck_en, h_en);
                    check("hold_idx", o_wbck_rdidx, h_idx);
                end
                fresh = 0;
                if (o_ready) begin
                    check("data", o_wbck_data, q[0].data);
                    check("wbck_en", o_wbck_en, q[0].en);
                    check("rdidx", o_wbck_rdidx, q[0].idx);
                    void'(q.pop_front());
                    fresh = 1; held = 0;
                end else begin
                    check("ready_while_held", i_ready, 0);
                    h_data = o_wbck_data; h_en = o_wbck_en; h_idx = o_wbck_rdidx; held = 1;
                end
            end
        end else begin
            fresh = 1; held = 0;
            if (q.size() > 0) begin
                check("ready_in_shift", i_ready, 0);
                check("busy_in_shift", o_busy, 1);
            end
        end
    end

    initial begin
        logic [10:0] f;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_wbck_data, 0);
        check("rst_en", o_wbck_en, 0);
        check("rst_idx", o_wbck_rdidx, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", i_ready, 1);
        @(posedge clk); #1;
        issue(ADD, 32'hFFFF_FFFF, 32'd1, 0, 1, 5'd7);
        issue(SLT, 32'hFFFF_FFFF, 32'd1, 0, 1, 5'd1);
        issue(SLTU, 32'hFFFF_FFFF, 32'd1, 0, 1, 5'd2);
        issue(LUI, 0, 0, 32'h1234_5000, 1, 5'd3);
        issue(SRA, 32'h8000_0000, 32'd13, 0, 1, 5'd4);
        issue(SLL, 32'd1, 32'd31, 0, 0, 5'd5);
        issue(11'h000, 32'h55, 32'h66, 32'h77, 1, 5'd6);
        repeat (12) @(posedge clk);
        #1 o_ready = 0;
        issue(XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1, 5'd9);
        fork
            issue(AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1, 5'd10);
            begin repeat (4) @(posedge clk); #1 o_ready = 1; end
        join
        repeat (3) @(posedge clk); #1;
        issue(SRL, 32'hFFFF_FFFF, 32'd20, 0, 1, 5'd11);
        @(posedge clk); #1 i_flush = 1;
        @(posedge clk); #1 i_flush = 0;
        q.delete();
        @(negedge clk);
        check("flush_valid", o_valid, 0);
        check("flush_ready", i_ready, 1);
        check("flush_busy", o_busy, 0);
        repeat (8) @(posedge clk); #1;
        issue(ADD, 32'd2, 32'd3, 0, 1, 5'd12);
        issue(SRA, 32'h8000_0000, 32'd29, 0, 1, 5'd13);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        q.delete();
        @(negedge clk);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_data", o_wbck_data, 0);
        check("mid_rst_en", o_wbck_en, 0);
        check("mid_rst_idx", o_wbck_rdidx, 0);
        check("mid_rst_busy", o_busy, 0);
        @(posedge clk); #1;
        issue(SLL, 32'h0000_ABCD, 32'd0, 0, 1, 5'd14);
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                7: f = 0;
                8: f = 11'($urandom);
                9: f = 11'($urandom) & 11'h0C4 | 11'($urandom_range(0, 1) << 5);
                default: f = 11'(1) << $urandom_range(0, 10);
            endcase
            issue(f, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom,
                  $urandom, 1'($urandom), 5'($urandom));
            if ($urandom_range(0, 4) == 0) begin repeat ($urandom_range(1, 4)) @(posedge clk); #1; end
        end
        rand_ready = 0;
        @(posedge clk); #1 o_ready = 1;
        for (int t = 0; t < 100 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            compared++; mismatched++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/xf100_exu_malu.md
Name: xf100_exu_malu

Overview:
- Parameterised multi-cycle ALU for the xf100 EXU.
- Covers the full RV32I ALU op set, including SLL/SRL/SRA, which the single-cycle ALU leaves unimplemented.
- Shifts are done by an iterative shifter that moves up to SHIFT_STEP bits per cycle. All other ops finish in one registered cycle.
- Sits between dispatch and the writeback arbiter. Both sides use valid/ready handshakes, with a held output register and a flush input.

Parameters:
XLEN, 32, datapath width; power of two, >= 8
RFIDX_W, 5, register-file index width
SHAMT_W, 5, shift-amount width; must equal log2(XLEN)
SHIFT_STEP, 4, maximum bits shifted per cycle; 1..XLEN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  op request
i_ready  out  1  request accepted when i_valid && i_ready
i_info  in  11  one-hot op select: [0]ADD [1]SUB [2]SLL [3]SLT [4]SLTU [5]XOR [6]SRL [7]SRA [8]OR [9]AND [10]LUI
i_rs1  in  XLEN  operand 1
i_rs2  in  XLEN  operand 2; shift amount is i_rs2[SHAMT_W-1:0]
i_imm  in  XLEN  immediate, used by LUI
i_rd_en  in  1  writeback enable
i_rdidx  in  RFIDX_W  destination index
i_flush  in  1  abort in-flight op and discard held result
o_valid  out  1  result valid
o_ready  in  1  writeback accepts result
o_wbck_en  out  1  registered i_rd_en
o_wbck_data  out  XLEN  result
o_wbck_rdidx  out  RFIDX_W  registered i_rdidx
o_busy  out  1  state != IDLE or o_valid

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; o_valid, o_wbck_en, o_wbck_data and o_wbck_rdidx all 0.
  - rst overrides every other input, including in mid-shift.
- States:
  - IDLE: no op in flight.
  - SHIFT: iterating; holds acc (XLEN), rem (SHAMT_W), kind (SLL/SRL/SRA), rd_en, rdidx.
- i_ready = (state==IDLE) && (!o_valid || o_ready) && !i_flush.
  - At most one op is in flight; there is no input queue.
- Non-shift op accepted in IDLE: the next edge loads the output registers and sets o_valid=1 (latency 1).
  - Result is the AND-OR of the selected results.
  - ADD: rs1+rs2 mod 2^XLEN.
  - SUB: rs1-rs2 mod 2^XLEN.
  - SLT: signed rs1<rs2 ? 1 : 0.
  - SLTU: unsigned rs1<rs2 ? 1 : 0.
  - XOR / OR / AND: bitwise on rs1, rs2.
  - LUI: i_imm.
  - SLT/SLTU use an XLEN+1-bit subtract: sign-extended for SLT, zero-extended for SLTU; the result is the borrow bit.
  - i_info all-zero: result 0, o_valid still asserts.
- Shift op accepted with shamt==0: same as non-shift, result = rs1, latency 1.
- Shift op accepted with shamt>0: go to SHIFT with acc=rs1, rem=shamt.
  - Each SHIFT cycle shifts acc by step=min(rem, SHIFT_STEP) and sets rem -= step.
  - SRA fills with acc[XLEN-1]; SLL/SRL fill with 0.
  - The edge on which rem reaches 0 loads the output registers, sets o_valid=1 and returns to IDLE.
  - Latency from acceptance to o_valid = 1 + ceil(shamt/SHIFT_STEP).
  - If several shift bits are set, priority is SRA > SRL > SLL, and non-shift bits are ignored.
- Output hold: while o_valid && !o_ready, all o_* outputs stay stable.
  - o_valid drops on the edge after the o_valid && o_ready handshake, unless a new result loads on that same edge.
  - Back-to-back single-cycle ops sustain 1 op/cycle when o_ready=1.
- Flush (i_flush=1 at an edge):
  - state -> IDLE and o_valid -> 0; the SHIFT datapath contents are dropped.
  - Flush overrides both acceptance and completion on the same edge.
  - o_wbck_* data need not clear.
- o_wbck_en/o_wbck_rdidx are carried unchanged from the request. Ops with i_rd_en=0 still complete and handshake.

Test Plan:
- ADD rs1=0xFFFFFFFF, rs2=1, rd_en=1, rdidx=7, o_ready=1 -> next cycle o_valid=1, data=0x00000000, rdidx=7, wbck_en=1.
- SLT rs1=0xFFFFFFFF, rs2=1 -> data=1; SLTU with the same operands -> data=0; LUI imm=0x12345000 -> data=0x12345000.
- SRA rs1=0x80000000, rs2=13 (SHIFT_STEP=4) -> o_valid 5 cycles after acceptance, data=0xFFFC0000; i_ready=0 throughout; SLL rs1=1, rs2=31 -> latency 9, data=0x80000000.
- XOR rs1=0xF0F0F0F0, rs2=0xFF00FF00 with o_ready=0 for 4 cycles -> data=0x0FF00FF0 held stable, i_ready=0; a queued AND is accepted only on the handshake cycle.
- SRL rs1=0xFFFFFFFF, rs2=20; i_flush pulsed on the 2nd SHIFT cycle -> no o_valid, IDLE the next cycle, i_ready=1; a following ADD 2+3 returns 5.
- rst asserted in mid-shift -> the next cycle has o_valid=0, all outputs 0, state IDLE; shamt=0 SLL rs1=0xABCD -> latency 1, data=0x0000ABCD.
